// File: rtl/pipe_ctrl_pkg.sv
// Shared core package for the pipeline controller: state encoding, address
// widths and the default fetch-timeout threshold.
package pipe_ctrl_pkg;

  localparam int unsigned FETCH_TIMEOUT_DEFAULT = 16;
  localparam int unsigned REG_ADDR_W            = 5;
  localparam int unsigned FWAIT_W               = 8;

  typedef enum logic [2:0] {
    CTRL_RESET      = 3'd0,
    CTRL_RUN        = 3'd1,
    CTRL_MEM_WAIT   = 3'd2,
    CTRL_FLUSH      = 3'd3,
    CTRL_LOAD_USE   = 3'd4,
    CTRL_FETCH_WAIT = 3'd5
  } ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect: purely combinational load-use comparator.
// Ports:
//   id_rs1_addr_i/id_rs2_addr_i  source registers of the instruction in ID
//   id_uses_rs1_i/id_uses_rs2_i  the ID instruction reads that source
//   ex_is_load_i                 the EX instruction is a load
//   ex_rd_addr_i                 destination register of the EX instruction
//   lu_o                         load-use hazard present this cycle
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
  input  logic                  id_uses_rs1_i,
  input  logic                  id_uses_rs2_i,
  input  logic                  ex_is_load_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
  output logic                  lu_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_uses_rs1_i && (id_rs1_addr_i == ex_rd_addr_i);
  assign rs2_hit = id_uses_rs2_i && (id_rs2_addr_i == ex_rd_addr_i);

  // x0 is never written, so a load targeting it cannot create a dependency.
  assign lu_o = ex_is_load_i && (ex_rd_addr_i != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard and stall controller for the IF/ID/EX pipeline.
// Decides per cycle which stages hold and which pipeline registers take a
// bubble, tracks controller state, and flags a stuck instruction fetch.
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   imem_ready                          fetch data valid this cycle
//   id_rs1_addr/id_rs2_addr/id_uses_*   ID source operands
//   ex_is_load/ex_rd_addr               EX load and its destination
//   ex_take_branch                      taken branch/jump in EX
//   lsu_busy                            data-memory access outstanding
//   if_stall/id_stall/ex_stall          hold PC, IF/ID, ID/EX (combinational)
//   id_flush/ex_flush                   bubble into IF/ID, ID/EX (combinational)
//   ctrl_state                          current state, debug
//   fetch_err                           sticky fetch-timeout flag
//   perf_*                              performance counters
// Optional feature: define PIPE_CTRL_PERF_EN to build the perf counters;
// otherwise the perf_* ports are tied to zero.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FETCH_TIMEOUT = FETCH_TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             imem_ready,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_take_branch,
  input  logic             lsu_busy,
  output logic             if_stall,
  output logic             id_stall,
  output logic             ex_stall,
  output logic             id_flush,
  output logic             ex_flush,
  output logic [2:0]       ctrl_state,
  output logic             fetch_err,
  output logic [CNT_W-1:0] perf_stall_cycles,
  output logic [CNT_W-1:0] perf_flushes,
  output logic [CNT_W-1:0] perf_load_use
);

  ctrl_state_e        state_q, state_d;
  logic [FWAIT_W-1:0] fwait_cnt_q, fwait_cnt_d;
  logic               fetch_err_q;
  logic               fetch_timeout;
  logic               lu;

  hazard_detect u_hazard_detect (
    .id_rs1_addr_i (id_rs1_addr),
    .id_rs2_addr_i (id_rs2_addr),
    .id_uses_rs1_i (id_uses_rs1),
    .id_uses_rs2_i (id_uses_rs2),
    .ex_is_load_i  (ex_is_load),
    .ex_rd_addr_i  (ex_rd_addr),
    .lu_o          (lu)
  );

  // Priority decode: first matching condition sets outputs and next state.
  always_comb begin
    state_d  = state_q;
    if_stall = 1'b0;
    id_stall = 1'b0;
    ex_stall = 1'b0;
    id_flush = 1'b0;
    ex_flush = 1'b0;
    if (state_q == CTRL_RESET) begin
      if_stall = 1'b1;
      id_stall = 1'b1;
      ex_stall = 1'b1;
      id_flush = 1'b1;
      ex_flush = 1'b1;
      state_d  = CTRL_RUN;
    end else if (lsu_busy) begin
      // A taken branch stays parked in EX until the memory access finishes.
      if_stall = 1'b1;
      id_stall = 1'b1;
      ex_stall = 1'b1;
      state_d  = CTRL_MEM_WAIT;
    end else if (ex_take_branch) begin
      // PC loads the target regardless of imem_ready.
      id_flush = 1'b1;
      ex_flush = 1'b1;
      state_d  = CTRL_FLUSH;
    end else if (lu) begin
      if_stall = 1'b1;
      id_stall = 1'b1;
      ex_flush = 1'b1;
      state_d  = CTRL_LOAD_USE;
    end else if (!imem_ready) begin
      if_stall = 1'b1;
      id_flush = 1'b1;
      state_d  = CTRL_FETCH_WAIT;
    end else begin
      state_d  = CTRL_RUN;
    end
  end

  // Fetch watchdog: saturating count of consecutive not-ready cycles.
  always_comb begin
    fwait_cnt_d = fwait_cnt_q;
    if (imem_ready) begin
      fwait_cnt_d = '0;
    end else if (fwait_cnt_q != {FWAIT_W{1'b1}}) begin
      fwait_cnt_d = fwait_cnt_q + FWAIT_W'(1);
    end
  end

  assign fetch_timeout = !imem_ready && (fwait_cnt_q == FWAIT_W'(FETCH_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CTRL_RESET;
      fwait_cnt_q <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fwait_cnt_q <= fwait_cnt_d;
      if (fetch_timeout) begin
        fetch_err_q <= 1'b1;
      end
    end
  end

  assign ctrl_state = 3'(state_q);
  assign fetch_err  = fetch_err_q;

`ifdef PIPE_CTRL_PERF_EN
  logic             stall_evt;
  logic             branch_won;
  logic             lu_won;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] lu_cnt_q;

  assign stall_evt  = if_stall && (state_q != CTRL_RESET);
  assign branch_won = (state_q != CTRL_RESET) && !lsu_busy && ex_take_branch;
  assign lu_won     = (state_q != CTRL_RESET) && !lsu_busy && !ex_take_branch && lu;

  // Counters wrap naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      lu_cnt_q    <= '0;
    end else begin
      if (stall_evt)  stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (branch_won) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      if (lu_won)     lu_cnt_q    <= lu_cnt_q + CNT_W'(1);
    end
  end

  assign perf_stall_cycles = stall_cnt_q;
  assign perf_flushes      = flush_cnt_q;
  assign perf_load_use     = lu_cnt_q;
`else
  assign perf_stall_cycles = '0;
  assign perf_flushes      = '0;
  assign perf_load_use     = '0;
`endif

endmodule
